result_tx: RTL
==============

RESULT_TX -- requirements
Module: result_tx

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of 32-bit result entries buffered; DEPTH is a power of two and at least 2.
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; 0 = reset, sampled on the clk rising edge.
REQ-004 done  input  1  MAC completion flag; a 0->1 transition marks a new result.
REQ-005 result  input  32  MAC result, valid in the cycle done rises.
REQ-006 tx_data  output  16  outgoing half-word.
REQ-007 tx_valid  output  1  tx_data holds a half-word for transfer.
REQ-008 tx_ready  input  1  downstream accepts tx_data.
REQ-009 tx_last  output  1  high with the low (second) half-word of a result.
REQ-010 buf_count  output  $clog2(DEPTH)+1  number of occupied entries, including the one being sent.
REQ-011 overflow  output  1  sticky; a result was dropped because the buffer was full.
REQ-012 clear_overflow  input  1  clears overflow.

Function
REQ-013 Capture SHALL occur on a clk edge where done=1 and the registered done_q=0; done held high SHALL capture once only.
REQ-014 Capture SHALL write result at the write pointer; the pointer wraps modulo DEPTH.
REQ-015 Full is buf_count==DEPTH, evaluated before the edge; capture when full SHALL be dropped and SHALL set overflow.
REQ-016 Exception: capture when full SHALL be accepted if the same edge pops an entry; buf_count then stays at DEPTH.
REQ-017 Transfer SHALL occur on an edge where tx_valid=1 and tx_ready=1.
REQ-018 The FSM SHALL have three states: IDLE, SEND_HI and SEND_LO.
REQ-019 IDLE: tx_valid=0 and tx_data=0; if buf_count>0, the FSM SHALL move to SEND_HI.
REQ-020 SEND_HI: tx_valid=1, tx_data=head[31:16], tx_last=0; on transfer the FSM SHALL move to SEND_LO.
REQ-021 SEND_LO: tx_valid=1, tx_data=head[15:0], tx_last=1; on transfer the head entry SHALL be popped (read pointer +1, wrapping).
REQ-022 After the SEND_LO pop, the FSM SHALL go to SEND_HI if entries remain, with no idle cycle, and otherwise to IDLE.
REQ-023 While tx_valid=1 and tx_ready=0, tx_data and tx_last SHALL hold stable, and tx_valid SHALL NOT drop.
REQ-024 Latency: a capture at edge E0 from an empty, idle block SHALL give tx_valid=1 after edge E1.
REQ-025 buf_count SHALL increase by 1 on capture and decrease by 1 on pop; simultaneous capture and pop SHALL leave it unchanged.
REQ-026 Results SHALL be sent in capture order, high half-word first; there is no reordering or merging.
REQ-027 overflow SHALL clear on clear_overflow=1, except that a drop on the same edge wins (overflow=1).
REQ-028 tx_data, tx_valid and tx_last SHALL be driven from registers or from the state register only, with no combinational path from tx_ready.

Reset
REQ-029 On an edge with reset=0: state=IDLE, both pointers=0, buf_count=0, tx_valid=0, tx_data=0, tx_last=0, overflow=0, done_q=1.
REQ-030 done_q=1 after reset SHALL stop a done level held across reset release from capturing.
REQ-031 Reset mid-transfer SHALL discard all buffered and in-flight results, with tx_valid=0 from the following cycle.

Verification
REQ-032 Single result, tx_ready=1: done rises with result=0x1234ABCD -> tx 0x1234 (last=0), then 0xABCD (last=1), then IDLE, buf_count back to 0.
REQ-033 Backpressure: tx_ready=0 for 5 cycles during SEND_HI -> tx_data stays 0x1234 with tx_valid=1; after ready, 0xABCD follows.
REQ-034 Overflow: tx_ready=0, done pulsed 5 times with DEPTH=4 and values 1..5 -> buf_count=4, overflow=1, outputs 1..4 only; clear_overflow -> overflow=0.
REQ-035 Full with simultaneous pop: buffer full, done rises on the edge SEND_LO transfers -> new result accepted, buf_count=4, overflow=0.
REQ-036 Back-to-back: 3 results buffered, tx_ready=1 -> six consecutive transfers with no tx_valid gap, tx_last on the 2nd, 4th and 6th.
REQ-037 Reset: reset=0 in SEND_LO with done held high -> tx_valid=0 the next cycle, buf_count=0, and no capture after release until done falls and rises again.

Source files
------------

// File: rtl/result_tx.sv
// Result transmitter: captures 32-bit MAC results on done rising edges into a
// small FIFO and streams each one out as two 16-bit half-words, high half first.
module result_tx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done,
  input  logic [31:0]                result,
  output logic [15:0]                tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       tx_last,
  output logic [$clog2(DEPTH):0]     buf_count,
  output logic                       overflow,
  input  logic                       clear_overflow
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_next;
  logic [CNT_W-1:0]   count_next;
  logic               done_q;
  logic               rise;
  logic               full;
  logic               pop;
  logic               cap;
  logic               drop;
  logic [DATA_W-1:0]  head_next;
  logic [HALF_W-1:0]  tx_data_next;
  logic               tx_valid_next;
  logic               tx_last_next;

  // Buffer bookkeeping; a pop frees the slot a full-buffer capture needs.
  always_comb begin
    rise       = done & ~done_q;
    full       = (buf_count == CNT_W'(DEPTH));
    pop        = (state == SEND_LO) & tx_ready;
    cap        = rise & (~full | pop);
    drop       = rise & full & ~pop;
    rd_next    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_next = buf_count + CNT_W'(cap) - CNT_W'(pop);
  end

  // Next head: bypass the result being written into the slot that becomes head.
  always_comb begin
    head_next = mem[rd_next];
    if (cap && (wr_ptr == rd_next)) begin
      head_next = result;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_next    = state;
    tx_valid_next = 1'b0;
    tx_last_next  = 1'b0;
    tx_data_next  = '0;
    case (state)
      IDLE: begin
        if (buf_count != '0) begin
          state_next = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_ready) begin
          state_next = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_ready) begin
          state_next = (count_next != '0) ? SEND_HI : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    case (state_next)
      SEND_HI: begin
        tx_valid_next = 1'b1;
        tx_data_next  = head_next[DATA_W-1:HALF_W];
      end
      SEND_LO: begin
        tx_valid_next = 1'b1;
        tx_last_next  = 1'b1;
        tx_data_next  = head_next[HALF_W-1:0];
      end
      default: begin
        tx_valid_next = 1'b0;
      end
    endcase
  end

  // Control state; done_q resets high so a done level held through reset is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_last   <= 1'b0;
      overflow  <= 1'b0;
      done_q    <= 1'b1;
    end else begin
      state     <= state_next;
      rd_ptr    <= rd_next;
      buf_count <= count_next;
      tx_valid  <= tx_valid_next;
      tx_data   <= tx_data_next;
      tx_last   <= tx_last_next;
      done_q    <= done;
      if (cap) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage array needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem[wr_ptr] <= result;
    end
  end

endmodule
